spi_byte_writer: RTL and testbench
==================================

Name: spi_byte_writer

Overview:
- SPI receive-side address generator and deserializer. It is the write-direction counterpart of the read-side program counter.
- Shifts MOSI bits in, MSB first, on each qualified sclkPosEdge strobe from the serial clock divider.
- After every numBits bits it issues a one-cycle memory write of the assembled byte, then advances its address with wrap-around.
- Sits between the SPI pins and the memory write port, alongside the read-side counter that feeds SPI transmit.

Parameters:
addrWidth, 16, width of memAddr.
depth, 2**addrWidth, number of addressable words; the address wraps from depth-1 to 0.
numBits, 8, bits per word; this is also the width of memData.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
sclkPosEdge  input  1  one-clk strobe marking an SPI clock rising edge.
cs  input  1  SPI chip select, active low.
mosi  input  1  serial data in, sampled only on qualified strobes.
rxEn  input  1  receive enable; when low, strobes are ignored and all state is held.
memAddr  output  addrWidth  write address.
memData  output  numBits  assembled word presented to memory.
memWrEn  output  1  one-clk write strobe.
frameDone  output  1  one-clk pulse after cs deasserts.

Behaviour:
- Reset (async assert, takes effect immediately): memAddr=0, memData=0, memWrEn=0, frameDone=0. Internal shift register=0, bitCount=0, csPrev=1, state=IDLE.
- Qualified sample: a clk edge with sclkPosEdge=1, rxEn=1 and cs=0.
  - shiftReg <= {shiftReg[numBits-2:0], mosi}.
  - bitCount <= bitCount+1.
  - bitCount is ceil(log2(numBits)) bits wide.
- States:
  - IDLE: cs=1. bitCount is held at 0 and shiftReg is not updated. Go to SHIFT when cs=0.
  - SHIFT: accept qualified samples. A sample taken with bitCount==numBits-1 completes a word. On that edge: bitCount<=0 and the next state is WRITE.
  - WRITE: lasts exactly one clk.
- Write timing (cycle N = edge of the completing sample):
  - Cycle N+1: memWrEn=1, memData=the completed word (first received bit in the MSB), memAddr=A.
  - Cycle N+2: memWrEn=0. memAddr=A+1, or 0 when A==depth-1.
  - memData holds its value until the next write.
  - The next state after WRITE is SHIFT if cs=0, otherwise IDLE.
- Qualified samples that arrive during WRITE are accepted into the next word. The write does not drop them.
- A write already in WRITE completes even if cs rises or rxEn falls in that cycle.
- cs deasserted mid-word: bitCount is cleared, the partial word is discarded, and no write occurs. memAddr is unchanged, so the address persists across frames.
- cs rising on the same edge as would-be bit numBits: the sample is not qualified, so there is no write.
- frameDone: csPrev registers cs. frameDone=1 for exactly one clk, on the cycle after a 0->1 transition of cs is detected. It fires whether or not a partial word was discarded.
- rxEn=0: strobes are ignored. bitCount and shiftReg hold, so a partial word resumes when rxEn returns to 1.
- memWrEn is never high on two consecutive clks.

Test Plan:
1. Reset mid-operation: assert reset after 5 bits received -> all outputs 0 immediately. Then send 8 bits 0xC3 -> one write of data 0xC3 at addr 0.
2. Two bytes: cs=0, send 0xA5 then 0x3C on strobes every 4 clks -> memWrEn pulses twice, one clk each:
   - first at addr 0 with data 0xA5,
   - second at addr 1 with data 0x3C.
   After the second write, memAddr=2.
3. Partial abort: send 5 bits, raise cs -> no memWrEn, memAddr unchanged, frameDone pulses once. A new frame sending 0xFF writes at the same address.
4. rxEn pause: send 4 bits of 0x96, drop rxEn for 6 strobes while toggling mosi, raise rxEn, send the remaining 4 bits -> a single write of 0x96.
5. Wrap: with addrWidth=4, send 17 bytes -> the 16th write is at addr 15, the 17th at addr 0, and memAddr=1 afterwards.
6. Back-to-back: sclkPosEdge asserted on every clk (divider 1) -> each completed word is written, and the strobe landing in the WRITE cycle becomes bit 7 (MSB) of the next word.

Source files
------------

// File: rtl/spi_byte_writer.sv
// SPI receive-side deserializer: shifts MOSI in MSB first on qualified sclk strobes,
// writes each completed word to memory and advances a wrapping write address.
module spi_byte_writer #(
  parameter int addrWidth = 16,
  parameter int depth     = 2**addrWidth,
  parameter int numBits   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclkPosEdge,
  input  logic                 cs,
  input  logic                 mosi,
  input  logic                 rxEn,
  output logic [addrWidth-1:0] memAddr,
  output logic [numBits-1:0]   memData,
  output logic                 memWrEn,
  output logic                 frameDone
);

  localparam int CNT_W = (numBits > 1) ? $clog2(numBits) : 1;
  localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(numBits - 1);
  localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(depth - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [numBits-1:0]   shift_reg;
  logic [CNT_W-1:0]     bit_count;
  logic                 cs_prev;
  logic                 accept;
  logic                 word_done;
  logic [numBits-1:0]   word_next;

  // Samples are taken in WRITE too, so a strobe in the write cycle starts the next word.
  assign accept    = sclkPosEdge & rxEn & ~cs & (state_reg != IDLE);
  assign word_done = accept & (bit_count == LAST_BIT);
  assign word_next = {shift_reg[numBits-2:0], mosi};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!cs) state_next = SHIFT;
      end
      SHIFT: begin
        if (word_done)  state_next = WRITE;
        else if (cs)    state_next = IDLE;
      end
      WRITE: begin
        state_next = cs ? IDLE : SHIFT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    memWrEn = (state_reg == WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_count <= '0;
      cs_prev   <= 1'b1;
      frameDone <= 1'b0;
      memData   <= '0;
      memAddr   <= '0;
    end else begin
      cs_prev   <= cs;
      frameDone <= cs & ~cs_prev;

      // A raised cs throws away any partial word; rxEn low simply freezes it.
      if (cs) begin
        bit_count <= '0;
      end else if (accept) begin
        shift_reg <= word_next;
        bit_count <= word_done ? '0 : bit_count + CNT_W'(1);
      end

      if (word_done) begin
        memData <= word_next;
      end

      if (state_reg == WRITE) begin
        memAddr <= (memAddr == LAST_ADDR) ? '0 : memAddr + addrWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_writer.sv
// Directed-plus-random bench for spi_byte_writer; a bit-queue reference model predicts
// every memory write (address, data) and the final write address.
module tb_spi_byte_writer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sclkPosEdge = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic          rxEn = 1'b1;
  logic [AW-1:0] memAddr;
  logic [NB-1:0] memData;
  logic          memWrEn;
  logic          frameDone;

  int compared   = 0;
  int mismatched = 0;

  logic [AW+NB-1:0] obs_q[$];
  logic [AW+NB-1:0] exp_q[$];
  logic             bits_q[$];
  int               m_addr = 0;
  int               fd_count = 0;
  logic             prev_we = 1'b0;

  spi_byte_writer #(.addrWidth(AW), .depth(DEPTH), .numBits(NB)) dut (
    .clk(clk),
    .reset(reset),
    .sclkPosEdge(sclkPosEdge),
    .cs(cs),
    .mosi(mosi),
    .rxEn(rxEn),
    .memAddr(memAddr),
    .memData(memData),
    .memWrEn(memWrEn),
    .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  // Record every write and frame pulse; a write strobe must never follow another.
  always @(negedge clk) begin
    if (memWrEn === 1'b1) begin
      obs_q.push_back({memAddr, memData});
      $display("write addr=%0d data=%02h", memAddr, memData);
      compared++;
      assert (prev_we === 1'b0) else begin
        mismatched++;
        $error("FAIL we_consecutive observed=%b expected=0", prev_we);
      end
    end
    if (frameDone === 1'b1) fd_count++;
    prev_we = memWrEn;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every qualified bit joins the current word; a full word becomes one write.
  function automatic void model_sample(input logic b);
    logic [NB-1:0] w;
    bits_q.push_back(b);
    if (bits_q.size() == NB) begin
      w = '0;
      foreach (bits_q[i]) w[NB-1-i] = bits_q[i];
      exp_q.push_back({AW'(m_addr), w});
      m_addr = (m_addr + 1) % DEPTH;
      bits_q.delete();
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    mosi = b;
    sclkPosEdge = 1'b1;
    if (!cs && rxEn) model_sample(b);
    tick();
    sclkPosEdge = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_byte(input logic [NB-1:0] v, input int gap);
    for (int i = NB - 1; i >= 0; i--) strobe(v[i], gap);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick();
    tick();
  endtask

  task automatic cs_high();
    cs = 1'b1;
    bits_q.delete();
    tick();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_addr"}, memAddr, 0);
    check({tag, "_data"}, memData, 0);
    check({tag, "_we"}, memWrEn, 0);
    check({tag, "_fd"}, frameDone, 0);
    bits_q.delete();
    m_addr = 0;
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_writes(input string tag);
    repeat (3) tick();
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          fd0;
    int          n;
    logic [AW-1:0] a15;
    logic [AW-1:0] a16;

    #2 reset = 1'b1;
    #1;
    check("rst_addr", memAddr, 0);
    check("rst_data", memData, 0);
    check("rst_we", memWrEn, 0);
    check("rst_fd", frameDone, 0);
    tick();
    reset = 1'b0;
    tick();

    // Two bytes, strobe every 4 clks
    cs_low();
    send_byte(8'hA5, 3);
    send_byte(8'h3C, 3);
    check_writes("two_bytes");
    check("two_bytes_addr", memAddr, 2);
    fd0 = fd_count;
    cs_high();
    repeat (3) tick();
    check("frame_fd", fd_count - fd0, 1);

    // Partial abort after 5 bits
    cs_low();
    for (int i = 0; i < 5; i++) strobe(1'($urandom_range(0, 1)), 1);
    fd0 = fd_count;
    cs_high();
    repeat (4) tick();
    check_writes("partial_abort");
    check("partial_addr", memAddr, 2);
    check("partial_fd", fd_count - fd0, 1);
    cs_low();
    send_byte(8'hFF, 2);
    check_writes("after_abort");

    // cs rising on the edge that would carry bit 8
    for (int i = 0; i < 7; i++) strobe(1'($urandom_range(0, 1)), 1);
    cs = 1'b1;
    bits_q.delete();
    strobe(1'b1, 3);
    check_writes("cs_on_last_bit");
    check("cs_on_last_bit_addr", memAddr, 3);
    cs_low();

    // rxEn pause in the middle of 0x96
    for (int i = 7; i >= 4; i--) strobe(1'((8'h96 >> i) & 1), 1);
    rxEn = 1'b0;
    repeat (6) strobe(1'($urandom_range(0, 1)), 1);
    rxEn = 1'b1;
    for (int i = 3; i >= 0; i--) strobe(1'((8'h96 >> i) & 1), 1);
    check("rxen_data", memData, 8'h96);
    check_writes("rxen_pause");

    // Reset in the middle of a word
    for (int i = 0; i < 5; i++) strobe(1'($urandom_range(0, 1)), 1);
    do_reset("rst_mid");
    send_byte(8'hC3, 3);
    check_writes("after_reset");
    check("after_reset_addr", memAddr, 1);

    // Address wrap over 17 bytes
    do_reset("rst_wrap");
    for (int k = 0; k < 17; k++) send_byte(8'($urandom), $urandom_range(0, 3));
    repeat (3) tick();
    a15 = (obs_q.size() > 15) ? obs_q[15][AW+NB-1:NB] : 'x;
    a16 = (obs_q.size() > 16) ? obs_q[16][AW+NB-1:NB] : 'x;
    check("wrap_16th_addr", a15, 15);
    check("wrap_17th_addr", a16, 0);
    check_writes("wrap");
    check("wrap_final_addr", memAddr, 1);

    // Strobe on every clk
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
    check_writes("back_to_back");
    check("back_to_back_addr", memAddr, m_addr);

    // Random frames with rxEn gaps and random lengths
    for (int f = 0; f < 6; f++) begin
      cs_high();
      cs_low();
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        rxEn = ($urandom_range(0, 3) != 0);
        strobe(1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
      rxEn = 1'b1;
      cs_high();
      check_writes("rand_frame");
      check("rand_frame_addr", memAddr, m_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
